// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, completion status and instruction class.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [1:0] {
    RobEmpty = 2'd0,
    RobWait  = 2'd1,
    RobDone  = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    OpAlu    = 3'd0,
    OpLoad   = 3'd1,
    OpStore  = 3'd2,
    OpBranch = 3'd3,
    OpJal    = 3'd4,
    OpJalr   = 3'd5,
    OpLui    = 3'd6,
    OpAuipc  = 3'd7
  } types_t;

  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] rd_data;
    rob_idx_t    rd_rob_idx;
  } rob_entry_t;

  function automatic logic entry_done(input rob_entry_t e);
    return e.valid && (e.status == RobDone);
  endfunction

  function automatic logic entry_waiting(input rob_entry_t e);
    return e.valid && (e.status == RobWait);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates at tail from dispatch, completes from the CDB,
// retires at most one finished entry per cycle from head, and serves operand lookups.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dis_valid,
  input  types_t           dis_op_type,
  input  logic [4:0]       dis_rd_addr,
  input  logic             dis_regf_we,
  output logic [IDX_W-1:0] dis_rob_idx,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_rob_idx,
  input  logic [31:0]      cdb_data,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_data,
  output logic [31:0]      q2_data,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_rob_idx,
  output logic [4:0]       commit_rd_addr,
  output logic             commit_regf_we,
  output logic [31:0]      commit_rd_data
);

  localparam logic [IDX_W:0]   FullCount = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] IdxOne    = IDX_W'(1);
  localparam logic [IDX_W:0]   CntOne    = (IDX_W + 1)'(1);

  rob_entry_t       rob_q [DEPTH];
  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;

  logic       do_alloc, do_commit, do_wb;
  rob_entry_t head_entry, new_entry;

  assign dis_rob_idx = tail_q;
  // Full is judged on registered count so a same-cycle commit never frees a slot early.
  assign rob_full    = (count_q == FullCount);
  assign head_entry  = rob_q[head_q];

  assign do_alloc  = dis_valid && !rob_full;
  assign do_commit = entry_done(head_entry);
  // The tail entry being allocated this edge is not yet valid, so a CDB hit on it is dropped.
  assign do_wb     = cdb_valid && entry_waiting(rob_q[cdb_rob_idx]);

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.status     = RobWait;
    new_entry.op_type    = dis_op_type;
    new_entry.rd_addr    = dis_rd_addr;
    new_entry.regf_we    = dis_regf_we;
    new_entry.rd_data    = '0;
    new_entry.rd_rob_idx = tail_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid   <= 1'b0;
      commit_rob_idx <= '0;
      commit_rd_addr <= '0;
      commit_regf_we <= 1'b0;
      commit_rd_data <= '0;
    end else begin
      // Writeback, allocate and commit always touch distinct slots: wb needs a waiting
      // entry, commit a done one, and the tail slot is empty whenever allocation happens.
      if (do_wb) begin
        rob_q[cdb_rob_idx].rd_data <= cdb_data;
        rob_q[cdb_rob_idx].status  <= RobDone;
      end
      if (do_alloc) begin
        rob_q[tail_q] <= new_entry;
        tail_q        <= tail_q + IdxOne;
      end
      commit_valid <= do_commit;
      if (do_commit) begin
        commit_rob_idx <= head_q;
        commit_rd_addr <= head_entry.rd_addr;
        commit_regf_we <= head_entry.regf_we;
        commit_rd_data <= head_entry.rd_data;
        rob_q[head_q]  <= '0;
        head_q         <= head_q + IdxOne;
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  function automatic logic [32:0] lookup(input rob_entry_t e, input logic hit,
                                         input logic [31:0] byp_data);
    if (entry_done(e)) begin
      return {1'b1, e.rd_data};
    end else if (e.valid && hit) begin
      return {1'b1, byp_data};
    end
    return '0;
  endfunction

  always_comb begin
    {q1_ready, q1_data} = lookup(rob_q[q1_idx], cdb_valid && (cdb_rob_idx == q1_idx), cdb_data);
    {q2_ready, q2_data} = lookup(rob_q[q2_idx], cdb_valid && (cdb_rob_idx == q2_idx), cdb_data);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer with a program-order queue model and a
// commit scoreboard checked by an independent monitor.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        dis_valid, dis_regf_we;
  types_t      dis_op_type;
  logic [4:0]  dis_rd_addr;
  logic [4:0]  dis_rob_idx;
  logic        rob_full;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic [31:0] cdb_data;
  logic [4:0]  q1_idx, q2_idx;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_valid, commit_regf_we;
  logic [4:0]  commit_rob_idx, commit_rd_addr;
  logic [31:0] commit_rd_data;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid), .dis_op_type(dis_op_type), .dis_rd_addr(dis_rd_addr),
    .dis_regf_we(dis_regf_we), .dis_rob_idx(dis_rob_idx), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .commit_rd_addr(commit_rd_addr), .commit_regf_we(commit_regf_we),
    .commit_rd_data(commit_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          done;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] data;
  } minst_t;

  minst_t mq[$];     // in-flight instructions, oldest first
  minst_t exp_q[$];  // expected retirements
  int     m_tail = 0;
  int     n_pass = 0, n_chk = 0;
  bit     chk_en = 0, mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int find(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic void qmodel(input int qi, output bit r, output logic [31:0] d);
    int p = find(qi);
    r = 0; d = '0;
    if (p >= 0 && mq[p].done) begin r = 1; d = mq[p].data; end
    else if (p >= 0 && cdb_valid && int'(cdb_rob_idx) == qi) begin r = 1; d = cdb_data; end
  endfunction

  // Advances the model across one clock edge using the inputs held during the cycle.
  task automatic model_edge();
    bit retire;
    int pre_size, p;
    if (!rst_n || flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    pre_size = mq.size();
    retire = (pre_size > 0) && mq[0].done;
    p = find(int'(cdb_rob_idx));
    if (cdb_valid && p >= 0 && !mq[p].done) begin
      mq[p].done = 1;
      mq[p].data = cdb_data;
    end
    if (retire) exp_q.push_back(mq.pop_front());
    if (dis_valid && pre_size < 32) begin
      mq.push_back('{idx: m_tail, done: 0, rd: dis_rd_addr, we: dis_regf_we, data: '0});
      m_tail = (m_tail + 1) % 32;
    end
  endtask

  task automatic tick();
    bit r;
    logic [31:0] d;
    #1;
    if (chk_en) begin
      chk("dis_rob_idx", 32'(dis_rob_idx), 32'(m_tail));
      chk("rob_full", 32'(rob_full), 32'(mq.size() == 32));
      qmodel(int'(q1_idx), r, d);
      chk("q1_ready", 32'(q1_ready), 32'(r));
      chk("q1_data", q1_data, d);
      qmodel(int'(q2_idx), r, d);
      chk("q2_ready", 32'(q2_ready), 32'(r));
      chk("q2_data", q2_data, d);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit dv, input int rd, input bit we, input bit cv, input int ci,
                       input logic [31:0] cd, input bit fl);
    dis_valid   = dv;
    dis_op_type = types_t'($urandom_range(0, 7));
    dis_rd_addr = 5'(rd);
    dis_regf_we = we;
    cdb_valid   = cv;
    cdb_rob_idx = 5'(ci);
    cdb_data    = cd;
    flush       = fl;
    q1_idx      = 5'($urandom_range(0, 31));
    q2_idx      = 5'(ci);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: checks every post-edge commit against the scoreboard.
  initial begin
    minst_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      chk("commit_valid", 32'(commit_valid), 32'(exp_q.size() > 0));
      if (commit_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("commit_rob_idx", 32'(commit_rob_idx), 32'(e.idx));
        chk("commit_rd_addr", 32'(commit_rd_addr), 32'(e.rd));
        chk("commit_regf_we", 32'(commit_regf_we), 32'(e.we));
        chk("commit_rd_data", commit_rd_data, e.data);
      end
    end
  end

  initial begin
    int w[$];
    rst_n = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk_en = 1;
    mon_en = 1;
    chk("reset_commit_valid", 32'(commit_valid), 32'd0);
    chk("reset_tail", 32'(dis_rob_idx), 32'd0);

    // Single instruction through dispatch, CDB and commit.
    drive(1, 5, 1, 0, 0, 0, 0);
    chk("tail_after_one", 32'(dis_rob_idx), 32'd1);
    idle(3);
    drive(0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    idle(3);
    chk("empty_tail", 32'(dis_rob_idx), 32'd1);

    // Out-of-order completion retires in order.
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 32'hC, 0);
    drive(0, 0, 0, 1, 2, 32'hB, 0);
    idle(2);
    drive(0, 0, 0, 1, 1, 32'hA, 0);
    idle(5);

    // Fill from an empty, flushed ROB; dispatch stays refused while full.
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) drive(1, i, 1, 0, 0, 0, 0);
    chk("full_after_32", 32'(rob_full), 32'd1);
    drive(0, 0, 0, 1, 3, 32'h55, 0);
    drive(1, 9, 1, 0, 0, 0, 0);
    drive(1, 9, 1, 1, 0, 32'h1234, 0);
    drive(1, 9, 1, 0, 0, 0, 0);
    drive(1, 7, 1, 0, 0, 0, 0);
    chk("wrap_tail", 32'(dis_rob_idx), 32'd1);

    // Flush with partially completed entries.
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, i + 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 0, 1, i, 32'(i * 17), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    chk("flush_tail", 32'(dis_rob_idx), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int ci;
      w.delete();
      foreach (mq[i]) if (!mq[i].done) w.push_back(mq[i].idx);
      if (w.size() > 0 && $urandom_range(0, 9) < 7) ci = w[$urandom_range(0, w.size() - 1)];
      else ci = $urandom_range(0, 31);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 31), 1'($urandom),
            $urandom_range(0, 9) < 7, ci, $urandom, $urandom_range(0, 199) == 0);
    end

    // Drain everything still in flight.
    for (int n = 0; n < 200 && mq.size() > 0; n++) begin
      int ci = mq[0].idx;
      foreach (mq[i]) if (!mq[i].done) begin ci = mq[i].idx; break; end
      drive(0, 0, 0, 1, ci, $urandom, 0);
    end
    idle(3);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
